sipo_deser: RTL and testbench

SIPO_DESER -- requirements
Module: sipo_deser

---
 rtl/sipo_deser.sv | 53 +++++
 tb/tb_sipo_deser.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deser.sv
// sipo_deser: serial-in parallel-out deserialiser with sync-marked framing and partial-word error strobe
module sipo_deser #(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     sdi,
  input  logic                     sdi_en,
  input  logic                     sync,
  output logic [WIDTH-1:0]         shift_r,
  output logic [WIDTH-1:0]         pdo,
  output logic                     pdo_valid,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     frame_err
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] shift_q, shift_d, pdo_q, pdo_d, shifted, seeded;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d, ferr_q, ferr_d, last;
  // next state: shift a bit in, restart the word on sync, capture a completed word
  always_comb begin
    shifted = (LSB_FIRST != 0) ? {sdi, shift_q[WIDTH-1:1]} : {shift_q[WIDTH-2:0], sdi};
    seeded  = (LSB_FIRST != 0) ? {sdi, {(WIDTH-1){1'b0}}} : {{(WIDTH-1){1'b0}}, sdi};
    last    = cnt_q == CW'(WIDTH - 1);
    shift_d = sync ? (sdi_en ? seeded : '0) : (sdi_en ? shifted : shift_q);
    cnt_d   = sync ? CW'(sdi_en) : (sdi_en ? (last ? '0 : cnt_q + CW'(1)) : cnt_q);
    valid_d = sdi_en && !sync && last;
    pdo_d   = valid_d ? shifted : pdo_q;
    ferr_d  = sync && (cnt_q != '0);
  end
  // state registers, cleared asynchronously so a reset drops any word in progress
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
      pdo_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      pdo_q   <= pdo_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end
  assign shift_r   = shift_q;
  assign pdo       = pdo_q;
  assign pdo_valid = valid_q;
  assign bit_cnt   = cnt_q;
  assign frame_err = ferr_q;
endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: three deserialiser configurations on shared stimulus, checked against a bit-history model
module tb_sipo_deser;
  logic clk = 1'b0;
  logic reset_n, sdi, sdi_en, sync;
  logic [3:0] sr0, pd0, sr1, pd1;
  logic [7:0] sr2, pd2;
  logic [1:0] bc0, bc1;
  logic [2:0] bc2;
  logic pv0, pv1, pv2, fe0, fe1, fe2;
  logic [31:0] sr[3], pd[3], bc[3];
  logic pv[3], fe[3];
  int W[3] = '{4, 4, 8};
  int L[3] = '{0, 1, 0};
  bit hist[$];
  int n = 0;
  logic [31:0] exp_pdo[3] = '{0, 0, 0};
  logic exp_v[3] = '{0, 0, 0};
  logic exp_fe[3] = '{0, 0, 0};
  logic [31:0] sbq[3][$];
  int asserts = 0, fails = 0;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(4), .LSB_FIRST(0)) d0 (.clk(clk), .reset_n(reset_n), .sdi(sdi), .sdi_en(sdi_en), .sync(sync),
    .shift_r(sr0), .pdo(pd0), .pdo_valid(pv0), .bit_cnt(bc0), .frame_err(fe0));
  sipo_deser #(.WIDTH(4), .LSB_FIRST(1)) d1 (.clk(clk), .reset_n(reset_n), .sdi(sdi), .sdi_en(sdi_en), .sync(sync),
    .shift_r(sr1), .pdo(pd1), .pdo_valid(pv1), .bit_cnt(bc1), .frame_err(fe1));
  sipo_deser #(.WIDTH(8), .LSB_FIRST(0)) d2 (.clk(clk), .reset_n(reset_n), .sdi(sdi), .sdi_en(sdi_en), .sync(sync),
    .shift_r(sr2), .pdo(pd2), .pdo_valid(pv2), .bit_cnt(bc2), .frame_err(fe2));

  assign sr[0] = 32'(sr0);
  assign sr[1] = 32'(sr1);
  assign sr[2] = 32'(sr2);
  assign pd[0] = 32'(pd0);
  assign pd[1] = 32'(pd1);
  assign pd[2] = 32'(pd2);
  assign bc[0] = 32'(bc0);
  assign bc[1] = 32'(bc1);
  assign bc[2] = 32'(bc2);
  assign pv[0] = pv0;
  assign pv[1] = pv1;
  assign pv[2] = pv2;
  assign fe[0] = fe0;
  assign fe[1] = fe1;
  assign fe[2] = fe2;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[dut%0d] @%0t: got %0h expected %0h", nm, k, $time, act, exp);
    end
  endtask

  // Expected shift register: the newest W bits since the last clear, newest at the shift-in end
  function automatic logic [31:0] exp_shift(input int k);
    logic [31:0] v = '0;
    int s = hist.size();
    for (int i = 0; i < W[k] && i < s; i++)
      if (hist[s-1-i]) v[(L[k] != 0) ? (W[k] - 1 - i) : i] = 1'b1;
    return v;
  endfunction

  // Expected completed word from the last W bits, first-received bit at MSB or LSB
  function automatic logic [31:0] exp_word(input int k);
    logic [31:0] v = '0;
    int s = hist.size();
    for (int i = 0; i < W[k]; i++)
      if (hist[s-W[k]+i]) v[(L[k] != 0) ? i : (W[k] - 1 - i)] = 1'b1;
    return v;
  endfunction

  task automatic step(input bit en, input bit sd, input bit sy);
    @(negedge clk);
    sdi_en = en;
    sdi = sd;
    sync = sy;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      exp_v[k] = 1'b0;
      exp_fe[k] = 1'b0;
    end
    if (sy) begin
      for (int k = 0; k < 3; k++) exp_fe[k] = (n % W[k]) != 0;
      hist.delete();
      n = 0;
      if (en) begin
        hist.push_back(sd);
        n = 1;
      end
    end else if (en) begin
      hist.push_back(sd);
      n++;
      if (hist.size() > 32) void'(hist.pop_front());
      for (int k = 0; k < 3; k++)
        if (n % W[k] == 0) begin
          exp_pdo[k] = exp_word(k);
          sbq[k].push_back(exp_pdo[k]);
          exp_v[k] = 1'b1;
        end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    sdi_en = 1'b0;
    sync = 1'b0;
    #2 reset_n = 1'b0;
    hist.delete();
    n = 0;
    for (int k = 0; k < 3; k++) begin
      exp_pdo[k] = '0;
      exp_v[k] = 1'b0;
      exp_fe[k] = 1'b0;
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_shift_r", k, sr[k], 0);
      chk("rst_pdo", k, pd[k], 0);
      chk("rst_bit_cnt", k, bc[k], 0);
      chk("rst_pdo_valid", k, 32'(pv[k]), 0);
      chk("rst_frame_err", k, 32'(fe[k]), 0);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Monitor: every cycle compare live state, and pop the scoreboard whenever a word is presented
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk("shift_r", k, sr[k], exp_shift(k));
      chk("bit_cnt", k, bc[k], 32'(n % W[k]));
      chk("pdo_valid", k, 32'(pv[k]), 32'(exp_v[k]));
      chk("frame_err", k, 32'(fe[k]), 32'(exp_fe[k]));
      chk("pdo_hold", k, pd[k], exp_pdo[k]);
      if (pv[k] === 1'b1) begin
        chk("sb_pending", k, 32'(sbq[k].size() > 0), 1);
        if (sbq[k].size() > 0) chk("sb_word", k, pd[k], sbq[k].pop_front());
      end
    end
  end

  initial begin
    bit b028[4] = '{1, 0, 1, 1};
    int s028[4] = '{1, 2, 5, 11};
    reset_n = 1'b0;
    sdi = 1'b0;
    sdi_en = 1'b0;
    sync = 1'b0;
    #12;
    for (int k = 0; k < 3; k++) begin
      chk("init_shift_r", k, sr[k], 0);
      chk("init_pdo", k, pd[k], 0);
      chk("init_bit_cnt", k, bc[k], 0);
      chk("init_pdo_valid", k, 32'(pv[k]), 0);
      chk("init_frame_err", k, 32'(fe[k]), 0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, b028[i], 1'b0);
      #1 chk("msb_step", 0, sr[0], 32'(s028[i]));
    end
    chk("msb_word", 0, pd[0], 32'hB);
    chk("msb_valid", 0, 32'(pv[0]), 1);
    chk("msb_cnt_wrap", 0, bc[0], 0);
    chk("lsb_word", 1, pd[1], 32'hD);
    chk("lsb_valid", 1, 32'(pv[1]), 1);
    step(1'b0, 1'b0, 1'b1);
    #1 chk("sync_after_word_no_ferr", 0, 32'(fe[0]), 0);
    chk("valid_one_cycle", 0, 32'(pv[0]), 0);
    chk("pdo_kept", 0, pd[0], 32'hB);
    step(1'b1, 1'b1, 1'b0);
    repeat (3) begin
      step(1'b0, 1'b0, 1'b0);
      #1 chk("gap_frozen_sr", 0, sr[0], 1);
      chk("gap_frozen_cnt", 0, bc[0], 1);
    end
    step(1'b1, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    #1 chk("gap_word", 0, pd[0], 32'hD);
    chk("gap_valid", 0, 32'(pv[0]), 1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    #1 chk("resync_ferr", 0, 32'(fe[0]), 1);
    chk("resync_cnt", 0, bc[0], 1);
    chk("resync_sr", 0, sr[0], 1);
    chk("resync_pdo", 0, pd[0], 32'hD);
    chk("resync_lsb_sr", 1, sr[1], 32'h8);
    step(1'b0, 1'b0, 1'b1);
    repeat (5) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    #1 chk("post_reset_word", 2, 32'(pv[2]), 1);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
    end
    repeat (3) step(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk("sb_drained", k, 32'(sbq[k].size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
